serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, and presents the registered result with carry-out and signed overflow. A start/busy/done handshake lets the block trade area for latency, as the sequential successor to the combinational full-adder cell in the arithmetic datapath.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  mode captured with start: 0 = a+b+cin, 1 = a-b (cin ignored)
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in for add mode, captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result valid and updated
- sum  output  WIDTH  registered result; held between completions
- c_out  output  1  final carry out of the MSB; in sub mode, 1 = no borrow
- ovf  output  1  signed overflow: carry into MSB xor carry out of MSB

## Operation

- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge: load a into A shift register, b (sub=0) or ~b (sub=1) into B shift register, carry FF <= cin (sub=0) or 1 (sub=1), bit counter <= 0, go to RUN.
- RUN: busy=1. Each edge: full-adder on A[0], B[0], carry FF; sum bit shifts into the MSB of the working result register; carry FF <= generated carry; A and B shift right; counter increments. On the bit with counter = WIDTH-1, also capture the carry into that bit (carry FF before update) for ovf.
- After the WIDTH-th RUN edge: sum <= working register, c_out <= final carry, ovf <= carry_in_msb ^ final carry; go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally IDLE.
- start while in RUN or DONE is ignored and not queued.
- Arithmetic is modulo 2^WIDTH; sub uses two's complement (a + ~b + 1).
- Counter width: clog2(WIDTH)+1 bits, no wrap before terminal count.

## Timing

- Reset (any state, including mid-RUN): state IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, shift registers and carry FF cleared; an in-flight operation is discarded with no done pulse.
- start accepted at edge E0 -> busy=1 from E0 through edge E0+WIDTH; done=1, sum/c_out/ovf new values in the cycle following edge E0+WIDTH.
- Latency: WIDTH+1 cycles from accepting edge to done cycle inclusive of the done cycle.
- Throughput: a new start is accepted at the earliest one cycle after done (edge leaving DONE is not an accept edge; next IDLE edge is); period WIDTH+2 cycles.
- sum, c_out, ovf change only at completion or reset; stable at all other times.
- Operand inputs may change freely after the accepting edge.

## Test plan

- Assert rst for 2 cycles mid-idle and then idle -> busy=0, done=0, sum=8'h00, c_out=0, ovf=0.
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, sub=0, start one cycle -> busy high 8 cycles, done pulse one cycle, sum=8'h10, c_out=0, ovf=0.
- a=8'hFF, b=8'h01, cin=1, sub=0 -> sum=8'h01, c_out=1, ovf=0; then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, c_out=0, ovf=1.
- sub=1: a=8'h05, b=8'h07, cin=1 (ignored) -> sum=8'hFE, c_out=0, ovf=0; a=8'h80, b=8'h01 -> sum=8'h7F, c_out=1, ovf=1.
- Pulse start again 3 cycles into RUN with different operands -> ignored; only the original result appears; back-to-back start held high -> second accepted exactly WIDTH+2 cycles after first.
- Start, then rst at RUN cycle 4 -> no done pulse, outputs 0; WIDTH=4 exhaustive sweep of a, b, cin, sub (1024 cases) -> sum/c_out/ovf match reference model.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop process
// WIDTH-bit operands LSB first, with a start/busy/done handshake and registered results.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_d;

  // Full-adder cell on the current LSBs; the result register fills from the MSB side.
  always_comb begin
    fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    fa_c     = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    last_bit = (cnt_q == CW'(WIDTH - 1));
    res_d    = WIDTH'({fa_s, res_q} >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the +1 rides in on the carry flop.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= fa_c;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB, needed for signed overflow.
            sum     <= res_d;
            c_out   <= fa_c;
            ovf     <= carry_q ^ fa_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 vectors, handshake corner
// cases, and an exhaustive WIDTH=4 sweep against an arithmetic reference.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Launch one WIDTH=8 operation and return at the negedge where done is seen.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic sv, output int bc, output bit got_done);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; sub8 = sv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; cin8 = ~cv; sub8 = ~sv;
    bc = 0;
    got_done = 1'b0;
    for (int g = 0; g < 30 && !got_done; g++) begin
      if (done8) got_done = 1'b1;
      else begin
        if (busy8) bc++;
        @(negedge clk);
      end
    end
  endtask

  function automatic void ref4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                               input logic sv, output logic [3:0] s, output logic c,
                               output logic o);
    logic [3:0] bb;
    logic [4:0] f;
    bb = sv ? ~bv : bv;
    f  = {1'b0, av} + {1'b0, bb} + 5'(sv ? 1'b1 : cv);
    s  = f[3:0];
    c  = f[4];
    o  = (av[3] == bb[3]) && (s[3] != av[3]);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int         bc;
    bit         gd;
    int         cyc;
    int         nr;
    int         rises[4];
    logic       prev;
    bit         saw_done;
    logic [3:0] es;
    logic       ec, eo;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy",  64'(busy8), 64'(0));
    chk("reset_done",  64'(done8), 64'(0));
    chk("reset_sum",   64'(sum8),  64'(0));
    chk("reset_cout",  64'(cout8), 64'(0));
    chk("reset_ovf",   64'(ovf8),  64'(0));

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, bc, gd);
      chk($sformatf("vec%0d_done", i),  64'(gd),    64'(1));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(8));
      chk($sformatf("vec%0d_sum", i),   64'(sum8),  64'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i),  64'(cout8), 64'(vecs[i].c));
      chk($sformatf("vec%0d_ovf", i),   64'(ovf8),  64'(vecs[i].o));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 64'(done8), 64'(0));
      chk($sformatf("vec%0d_held_sum", i),   64'(sum8),  64'(vecs[i].s));
    end

    // Idle reset clears the previous (nonzero) result.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rst_sum",  64'(sum8),  64'(0));
    chk("idle_rst_cout", 64'(cout8), 64'(0));
    chk("idle_rst_ovf",  64'(ovf8),  64'(0));
    chk("idle_rst_busy", 64'(busy8), 64'(0));

    // start pulsed three cycles into RUN must be ignored and not queued.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    gd = 1'b0;
    for (int g = 0; g < 20 && !gd; g++) begin
      if (done8) gd = 1'b1;
      else @(negedge clk);
    end
    chk("ign_done", 64'(gd),    64'(1));
    chk("ign_sum",  64'(sum8),  64'(8'h10));
    chk("ign_cout", 64'(cout8), 64'(0));
    saw_done = 1'b0;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      if (busy8 || done8) saw_done = 1'b1;
    end
    chk("ign_not_queued", 64'(saw_done), 64'(0));

    // start held high: accepts spaced WIDTH+2 cycles apart.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    cyc = 0; nr = 0; prev = busy8;
    for (int i = 0; i < 4; i++) rises[i] = 0;
    for (int g = 0; g < 25; g++) begin
      @(negedge clk);
      cyc++;
      if (busy8 && !prev && nr < 4) begin
        rises[nr] = cyc;
        nr++;
      end
      prev = busy8;
    end
    start8 = 1'b0;
    chk("b2b_accepts", 64'(nr), 64'(3));
    chk("b2b_period",  64'(rises[1] - rises[0]), 64'(10));
    chk("b2b_period2", 64'(rises[2] - rises[1]), 64'(10));
    repeat (12) @(negedge clk);
    chk("b2b_sum", 64'(sum8), 64'(8'h10));

    // Reset at RUN cycle 4 discards the operation.
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy_before", 64'(busy8), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_busy", 64'(busy8), 64'(0));
    chk("midrun_sum",  64'(sum8),  64'(0));
    chk("midrun_cout", 64'(cout8), 64'(0));
    chk("midrun_ovf",  64'(ovf8),  64'(0));
    saw_done = 1'b0;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    chk("midrun_no_done", 64'(saw_done), 64'(0));

    // Exhaustive WIDTH=4 sweep.
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int x = 0; x < 16; x++) begin
          for (int y = 0; y < 16; y++) begin
            @(negedge clk);
            a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); sub4 = 1'(s); start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            a4 = ~a4; b4 = ~b4;
            gd = 1'b0;
            for (int g = 0; g < 20 && !gd; g++) begin
              if (done4) gd = 1'b1;
              else @(negedge clk);
            end
            ref4(4'(x), 4'(y), 1'(c), 1'(s), es, ec, eo);
            chk($sformatf("w4 a=%0h b=%0h cin=%0d sub=%0d result", x, y, c, s),
                64'({gd, cout4, ovf4, sum4}), 64'({1'b1, ec, eo, es}));
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
